ibex_axi4l_master: RTL and testbench



---
 rtl/ibex_axi4l_master_if.sv | 36 +++
 rtl/ibex_axi4l_master.sv | 146 ++++++++++++++
 tb/tb_ibex_axi4l_master.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_axi4l_master_if.sv
// AXI4-Lite bus bundle shared by the Ibex bridge (master) and its slave.
// aclk/aresetn ride along so the bridge has a single bus-facing port.
interface axi4l_if (
    input logic aclk,
    input logic aresetn
);
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        input  aclk, aresetn,
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  aclk, aresetn,
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ibex_axi4l_master.sv
// Bridges an Ibex req/gnt/rvalid memory port onto AXI4-Lite, one transaction in flight.
// Bus address/data/strobe come from latched registers so they hold steady while valid.
module ibex_axi4l_master #(
    parameter bit word_align = 1'b1
) (
    axi4l_if.master     axi,
    input  logic        req,
    output logic        gnt,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RRESP
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic [3:0]  r_be, w_be_nxt;
    logic        r_awvalid, w_awvalid_nxt;
    logic        r_wvalid, w_wvalid_nxt;
    logic        r_arvalid, w_arvalid_nxt;
    logic        r_rvalid, w_rvalid_nxt;
    logic        r_err, w_err_nxt;
    logic        w_aw_done, w_w_done;
    logic [31:0] w_bus_addr;

    always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
        if (!axi.aresetn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_be      <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_rdata   <= w_rdata_nxt;
            r_be      <= w_be_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // A channel counts as done once its valid has dropped or is handshaking now,
    // so simultaneous AW and W handshakes leave WRITE in a single cycle.
    assign w_aw_done = ~r_awvalid | axi.awready;
    assign w_w_done  = ~r_wvalid  | axi.wready;

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_rdata_nxt   = r_rdata;
        w_be_nxt      = r_be;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_arvalid_nxt = r_arvalid;
        w_rvalid_nxt  = 1'b0;
        w_err_nxt     = r_err;
        gnt           = 1'b0;
        case (r_state)
            S_IDLE: begin
                gnt = req;
                if (req) begin
                    w_addr_nxt  = addr;
                    w_wdata_nxt = wdata;
                    w_be_nxt    = be;
                    if (we) begin
                        w_state_nxt   = S_WRITE;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_READ;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (w_aw_done) w_awvalid_nxt = 1'b0;
                if (w_w_done)  w_wvalid_nxt  = 1'b0;
                if (w_aw_done && w_w_done) w_state_nxt = S_WRESP;
            end
            S_WRESP: begin
                if (axi.bvalid) begin
                    w_err_nxt    = (axi.bresp != RESP_OKAY);
                    w_rdata_nxt  = '0;
                    w_rvalid_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_READ: begin
                if (axi.arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_state_nxt   = S_RRESP;
                end
            end
            S_RRESP: begin
                if (axi.rvalid) begin
                    w_err_nxt    = (axi.rresp != RESP_OKAY);
                    w_rdata_nxt  = axi.rdata;
                    w_rvalid_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_bus_addr  = word_align ? {r_addr[31:2], 2'b00} : r_addr;

    assign axi.awvalid = r_awvalid;
    assign axi.awaddr  = w_bus_addr;
    assign axi.wvalid  = r_wvalid;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_be;
    assign axi.bready  = (r_state == S_WRESP);
    assign axi.arvalid = r_arvalid;
    assign axi.araddr  = w_bus_addr;
    assign axi.rready  = (r_state == S_RRESP);

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign err    = r_err;
endmodule

// File: tb/tb_ibex_axi4l_master.sv
// Bench for ibex_axi4l_master: vector table through a configurable-wait AXI slave model,
// scoreboard of expected responses, plus hand sequences for W back-pressure and mid-WRESP reset.
module tb_ibex_axi4l_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4l_if ifc  (.aclk(clk), .aresetn(rst_n));
    axi4l_if ifc2 (.aclk(clk), .aresetn(rst_n));

    logic        req, we, gnt, rvalid, err;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        gnt2, rvalid2, err2;
    logic [31:0] rdata2;

    ibex_axi4l_master #(.word_align(1'b1)) dut (
        .axi(ifc), .req(req), .gnt(gnt), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    ibex_axi4l_master #(.word_align(1'b0)) dut2 (
        .axi(ifc2), .req(req), .gnt(gnt2), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .rvalid(rvalid2), .rdata(rdata2), .err(err2)
    );

    // second instance sees exactly the same slave timing
    assign ifc2.awready = ifc.awready;
    assign ifc2.wready  = ifc.wready;
    assign ifc2.bvalid  = ifc.bvalid;
    assign ifc2.bresp   = ifc.bresp;
    assign ifc2.arready = ifc.arready;
    assign ifc2.rvalid  = ifc.rvalid;
    assign ifc2.rdata   = ifc.rdata;
    assign ifc2.rresp   = ifc.rresp;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- slave model ----------------
    int cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0, cfg_ar_wait = 0, cfg_r_wait = 0;
    logic [1:0] cfg_resp = 2'b00;
    logic [31:0] mem [64];
    logic s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
    logic s_aw_got = 1'b0, s_w_got = 1'b0, s_b_pend = 1'b0, s_r_pend = 1'b0;
    logic [31:0] s_waddr, s_wd, s_raddr;
    logic [3:0]  s_ws;
    int s_c_aw = 0, s_c_w = 0, s_c_b = 0, s_c_ar = 0, s_c_r = 0;

    always @(posedge clk) begin
        s_aw_hs = ifc.awvalid && ifc.awready;
        s_w_hs  = ifc.wvalid  && ifc.wready;
        s_b_hs  = ifc.bvalid  && ifc.bready;
        s_ar_hs = ifc.arvalid && ifc.arready;
        s_r_hs  = ifc.rvalid  && ifc.rready;
        if (s_aw_hs) begin s_waddr = ifc.awaddr; s_aw_got = 1'b1; end
        if (s_w_hs)  begin s_wd = ifc.wdata; s_ws = ifc.wstrb; s_w_got = 1'b1; end
        if (s_ar_hs) begin s_raddr = ifc.araddr; s_r_pend = 1'b1; s_c_r = 0; end
        #1;
        if (!rst_n) begin
            ifc.awready = 1'b1; ifc.wready = 1'b1; ifc.arready = 1'b1;
            ifc.bvalid = 1'b0; ifc.bresp = 2'b00;
            ifc.rvalid = 1'b0; ifc.rresp = 2'b00; ifc.rdata = '0;
            s_aw_got = 1'b0; s_w_got = 1'b0; s_b_pend = 1'b0; s_r_pend = 1'b0;
            s_c_aw = 0; s_c_w = 0; s_c_b = 0; s_c_ar = 0; s_c_r = 0;
        end else begin
            if (s_b_hs) ifc.bvalid = 1'b0;
            if (s_r_hs) ifc.rvalid = 1'b0;
            if (s_aw_got && s_w_got) begin
                for (int i = 0; i < 4; i++)
                    if (s_ws[i]) mem[s_waddr[7:2]][8*i +: 8] = s_wd[8*i +: 8];
                s_aw_got = 1'b0; s_w_got = 1'b0; s_b_pend = 1'b1; s_c_b = 0;
            end
            if (s_b_pend) begin
                if (s_c_b >= cfg_b_wait) begin
                    ifc.bvalid = 1'b1; ifc.bresp = cfg_resp; s_b_pend = 1'b0;
                end else s_c_b++;
            end
            if (s_r_pend) begin
                if (s_c_r >= cfg_r_wait) begin
                    ifc.rvalid = 1'b1; ifc.rresp = cfg_resp; ifc.rdata = mem[s_raddr[7:2]];
                    s_r_pend = 1'b0;
                end else s_c_r++;
            end
            if (s_aw_hs) s_c_aw = 0;
            if (s_w_hs)  s_c_w  = 0;
            if (s_ar_hs) s_c_ar = 0;
            ifc.awready = ifc.awvalid ? (s_c_aw >= cfg_aw_wait) : (cfg_aw_wait == 0);
            ifc.wready  = ifc.wvalid  ? (s_c_w  >= cfg_w_wait)  : (cfg_w_wait == 0);
            ifc.arready = ifc.arvalid ? (s_c_ar >= cfg_ar_wait) : (cfg_ar_wait == 0);
            if (ifc.awvalid) s_c_aw++; else s_c_aw = 0;
            if (ifc.wvalid)  s_c_w++;  else s_c_w  = 0;
            if (ifc.arvalid) s_c_ar++; else s_c_ar = 0;
        end
    end

    // ---------------- scoreboard and bus monitor ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          gcyc;
    } sb_t;
    sb_t sb[$];
    sb_t e;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic [3:0]  exp_be = '0;
    logic        r_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.awvalid)  chk("awaddr", ifc.awaddr, {exp_addr[31:2], 2'b00});
            if (ifc2.awvalid) chk("awaddr_raw", ifc2.awaddr, exp_addr);
            if (ifc.wvalid)   chk("wdata_wstrb", {ifc.wstrb, ifc.wdata}, {exp_be, exp_wdata});
            if (ifc.arvalid)  chk("araddr", ifc.araddr, {exp_addr[31:2], 2'b00});
            if (ifc2.arvalid) chk("araddr_raw", ifc2.araddr, exp_addr);
            if (ifc.bready)   chk("bready_after_aw_w", {ifc.awvalid, ifc.wvalid}, 2'b00);
            if (rvalid) begin
                chk("rvalid_pulse", r_prev, 1'b0);
                chk("rvalid_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rdata", rdata, e.rdata);
                    chk("err", err, e.err);
                    chk("latency", cyc - e.gcyc, e.lat);
                    chk("dut2_resp", {rvalid2, err2, rdata2}, {1'b1, e.err, e.rdata});
                end
            end
            r_prev = rvalid;
        end else r_prev = 1'b0;
    end

    // called #1 after a posedge; returns #1 after the posedge following the grant
    task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] er, input logic ee, input int lat);
        int n;
        exp_addr = a; exp_wdata = d; exp_be = b;
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        n = 0;
        @(negedge clk);
        while (!gnt && n < 50) begin n++; @(negedge clk); end
        chk("gnt", gnt, 1'b1);
        if (gnt) begin
            chk("gnt2", gnt2, 1'b1);
            sb.push_back('{er, ee, lat, cyc});
        end
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); be = 4'($urandom);
        addr = $urandom; wdata = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin n++; @(negedge clk); end
        chk("resp_arrived", sb.size() == 0, 1'b1);
        sb.delete();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_w, w_w, b_w, ar_w, r_w;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt[12];
    logic [2:0] wexp[6];
    int lat;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 4'hF, 32'h10, 32'h0,        0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 4'hF, 32'h20, 32'h12345678, 0, 0, 0, 0, 0, 2'b00, 32'h0,        1'b0};
        vt[3]  = '{1'b0, 4'hF, 32'h20, 32'h0,        0, 0, 0, 0, 0, 2'b10, 32'h12345678, 1'b1};
        vt[4]  = '{1'b0, 4'hF, 32'h10, 32'h0,        0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 1'b0};
        vt[5]  = '{1'b1, 4'h3, 32'h10, 32'hAAAA5555, 0, 0, 0, 0, 0, 2'b00, 32'h0,        1'b0};
        vt[6]  = '{1'b0, 4'hF, 32'h13, 32'h0,        0, 0, 0, 2, 1, 2'b00, 32'hDEAD5555, 1'b0};
        vt[7]  = '{1'b1, 4'hF, 32'h24, 32'h0BADF00D, 2, 0, 1, 0, 0, 2'b00, 32'h0,        1'b0};
        vt[8]  = '{1'b1, 4'hF, 32'h3C, 32'h11111111, 0, 1, 0, 0, 0, 2'b11, 32'h0,        1'b1};
        vt[9]  = '{1'b0, 4'hF, 32'h24, 32'h0,        0, 0, 0, 1, 0, 2'b00, 32'h0BADF00D, 1'b0};
        vt[10] = '{1'b1, 4'hC, 32'h22, 32'h55660000, 0, 2, 0, 0, 0, 2'b00, 32'h0,        1'b0};
        vt[11] = '{1'b0, 4'hF, 32'h20, 32'h0,        0, 0, 0, 0, 2, 2'b00, 32'h55665678, 1'b0};
        // {awvalid, wvalid, bready} for cycles 0..5 of a write with W held off 3 cycles
        wexp[0] = 3'b000; wexp[1] = 3'b110; wexp[2] = 3'b010;
        wexp[3] = 3'b010; wexp[4] = 3'b010; wexp[5] = 3'b001;

        req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus", {ifc.awvalid, ifc.wvalid, ifc.arvalid, ifc.bready, ifc.rready}, 5'b0);
        chk("rst_core", {rvalid, err, rdata}, 34'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            cfg_aw_wait = vt[i].aw_w; cfg_w_wait = vt[i].w_w; cfg_b_wait = vt[i].b_w;
            cfg_ar_wait = vt[i].ar_w; cfg_r_wait = vt[i].r_w; cfg_resp = vt[i].resp;
            lat = vt[i].we ? 3 + ((vt[i].aw_w > vt[i].w_w) ? vt[i].aw_w : vt[i].w_w) + vt[i].b_w
                           : 3 + vt[i].ar_w + vt[i].r_w;
            issue(vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err, lat);
            wait_idle();
        end
        cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 0; cfg_ar_wait = 0; cfg_r_wait = 0;
        cfg_resp = 2'b00;

        // W channel held off while AW completes immediately
        cfg_w_wait = 3;
        issue(1'b1, 4'hF, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 6);
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("wstall_c%0d", k), {ifc.awvalid, ifc.wvalid, ifc.bready}, wexp[k]);
        end
        @(posedge clk); #1;
        wait_idle();
        cfg_w_wait = 0;
        issue(1'b0, 4'hF, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 3);
        wait_idle();

        // reset while the write response is being presented
        issue(1'b1, 4'hF, 32'h34, 32'h77777777, 32'h0, 1'b0, 3);
        @(negedge clk);
        @(negedge clk);
        chk("wresp_reached", {ifc.bready, ifc.bvalid}, 2'b11);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_bus", {ifc.awvalid, ifc.wvalid, ifc.arvalid, ifc.bready, ifc.rready}, 5'b0);
        chk("midrst_core", {rvalid, err, rdata}, 34'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 1'b0;
        #1;
        chk("gnt_idle_noreq", gnt, 1'b0);
        req = 1'b1; we = 1'b0; addr = 32'h10;
        #1;
        chk("gnt_follows_req", gnt, 1'b1);
        req = 1'b0;
        @(negedge clk);
        chk("no_rvalid_after_rst", rvalid, 1'b0);
        @(posedge clk); #1;
        issue(1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD5555, 1'b0, 3);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
